// File: rtl/exe_muldiv.sv
// Iterative 64-bit multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply, restoring divide, with stall and flush handling.
module exe_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [2:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    input  logic            stall_out,
    output logic            exe_is_waiting,
    output logic [XLEN-1:0] result,
    output logic            done
);

    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic            mul_q, mul_d;
    logic            rem_q, rem_d;
    logic            word_q, word_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    function automatic logic [XLEN-1:0] fix_w(input logic w, input logic [XLEN-1:0] x);
        return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
    endfunction

    logic            op_div, op_divu, op_rem, op_remu, is_divop, sgn, sdiv;
    logic [XLEN-1:0] ea, eb, mag_a, mag_b, min_v, byp;
    logic            a_neg, b_neg, b_zero, ovf;

    always_comb begin
        op_div   = (op == 3'b001);
        op_divu  = (op == 3'b010);
        op_rem   = (op == 3'b011);
        op_remu  = (op == 3'b100);
        is_divop = op_div | op_divu | op_rem | op_remu;
        sdiv     = op_div | op_rem;
        sgn      = sdiv | !is_divop;
        if (is_word) begin
            ea = sgn ? {{(XLEN-32){srca[31]}}, srca[31:0]} : {{(XLEN-32){1'b0}}, srca[31:0]};
            eb = sgn ? {{(XLEN-32){srcb[31]}}, srcb[31:0]} : {{(XLEN-32){1'b0}}, srcb[31:0]};
            min_v = {{(XLEN-31){1'b1}}, 31'b0};
        end else begin
            ea = srca;
            eb = srcb;
            min_v = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg  = sdiv & ea[XLEN-1];
        b_neg  = sdiv & eb[XLEN-1];
        mag_a  = a_neg ? -ea : ea;
        mag_b  = b_neg ? -eb : eb;
        b_zero = (eb == '0);
        ovf    = sdiv & (ea == min_v) & (&eb);
        if (b_zero)
            byp = (op_div | op_divu) ? '1 : ea;
        else
            byp = op_div ? ea : '0;
    end

    // Division step compares the shifted-in partial remainder (XLEN+1 bits).
    logic [XLEN:0]   sub;
    logic [W2-1:0]   mul_step, div_step, step;
    logic [XLEN-1:0] q_v, r_v, fv;

    always_comb begin
        mul_step = {acc_q[W2-2:0], 1'b0} + (b_q[XLEN-1] ? {{XLEN{1'b0}}, a_q} : '0);
        sub      = acc_q[W2-1:XLEN-1] - {1'b0, b_q};
        if (!sub[XLEN])
            div_step = {sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_step = {acc_q[W2-2:0], 1'b0};
        step = mul_q ? mul_step : div_step;
        q_v  = step[XLEN-1:0];
        r_v  = step[W2-1:XLEN];
        if (mul_q)
            fv = q_v;
        else if (rem_q)
            fv = rneg_q ? -r_v : r_v;
        else
            fv = qneg_q ? -q_v : q_v;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        mul_d    = mul_q;
        rem_d    = rem_q;
        word_d   = word_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        done_d   = done_q;
        exe_is_waiting = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (valid && !flush) begin
                    exe_is_waiting = 1'b1;
                    mul_d  = !is_divop;
                    rem_d  = op_rem | op_remu;
                    word_d = is_word;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (is_divop && (b_zero || ovf)) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = fix_w(is_word, byp);
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = is_word ? 7'd32 : 7'd64;
                        if (!is_divop) begin
                            acc_d = '0;
                            a_d   = ea;
                            b_d   = is_word ? (eb << 32) : eb;
                        end else begin
                            acc_d = {{XLEN{1'b0}}, (is_word ? (mag_a << 32) : mag_a)};
                            a_d   = '0;
                            b_d   = mag_b;
                        end
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    exe_is_waiting = 1'b1;
                    acc_d = step;
                    b_d   = mul_q ? (b_q << 1) : b_q;
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = fix_w(word_q, fv);
                    end
                end
            end
            S_DONE: begin
                if (flush || !stall_out) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mul_q    <= 1'b0;
            rem_q    <= 1'b0;
            word_q   <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mul_q    <= mul_d;
            rem_q    <= rem_d;
            word_q   <= word_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed testbench for exe_muldiv.
// Each task drives one scenario and checks against hand-computed values.
module tb_exe_muldiv;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [2:0]  op;
    logic        is_word;
    logic [63:0] srca;
    logic [63:0] srcb;
    logic        flush;
    logic        stall_out;
    logic        exe_is_waiting;
    logic [63:0] result;
    logic        done;

    int total;
    int bad;

    localparam logic [2:0] MUL  = 3'b000;
    localparam logic [2:0] DIV  = 3'b001;
    localparam logic [2:0] DIVU = 3'b010;
    localparam logic [2:0] REM  = 3'b011;
    localparam logic [2:0] REMU = 3'b100;

    exe_muldiv #(.XLEN(64)) dut (
        .clk(clk),
        .reset(reset),
        .valid(valid),
        .op(op),
        .is_word(is_word),
        .srca(srca),
        .srcb(srcb),
        .flush(flush),
        .stall_out(stall_out),
        .exe_is_waiting(exe_is_waiting),
        .result(result),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one op and follows it to done; returns latency, waiting-cycle count and result.
    task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output int lat, output int wt,
                         output logic [63:0] res);
        @(posedge clk); #1;
        valid = 1'b1; op = o; is_word = w; srca = a; srcb = b;
        #1;
        wt  = int'(exe_is_waiting);
        lat = -1;
        res = '0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            valid = 1'b0;
            #1;
            if (done) begin
                lat = i;
                res = result;
                break;
            end
            wt += int'(exe_is_waiting);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (done !== 1'b0 || result !== 64'h0 || exe_is_waiting !== 1'b0) begin
            bad++;
            $display("FAIL reset: done=%b result=%h wait=%b, want 0/0/0", done, result, exe_is_waiting);
        end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        int lat, wt;
        logic [63:0] r;
        issue(MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, lat, wt, r);
        total++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            bad++; $display("FAIL mul_neg: got %h want ffffffffffffffeb", r);
        end
        total++;
        if (lat !== 65 || wt !== 65) begin
            bad++; $display("FAIL mul_timing: lat=%0d wait=%0d want 65/65", lat, wt);
        end
        issue(MUL, 1'b0, 64'h1_2345_6789, 64'h10, lat, wt, r);
        total++;
        if (r !== 64'h12_3456_7890) begin
            bad++; $display("FAIL mul_big: got %h want 1234567890", r);
        end
        issue(3'b111, 1'b0, 64'd3, 64'd5, lat, wt, r);
        total++;
        if (r !== 64'd15) begin
            bad++; $display("FAIL mul_op7: got %h want f", r);
        end
    endtask

    task automatic test_div();
        int lat, wt;
        logic [63:0] r;
        issue(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, wt, r);
        total++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            bad++; $display("FAIL div_neg: got %h want fffffffffffffffd", r);
        end
        total++;
        if (lat !== 65 || wt !== 65) begin
            bad++; $display("FAIL div_timing: lat=%0d wait=%0d want 65/65", lat, wt);
        end
        issue(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, wt, r);
        total++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL rem_neg: got %h want ffffffffffffffff", r);
        end
        issue(REMU, 1'b0, 64'd100, 64'd7, lat, wt, r);
        total++;
        if (r !== 64'd2) begin
            bad++; $display("FAIL remu: got %h want 2", r);
        end
        issue(DIVU, 1'b0, 64'd100, 64'd7, lat, wt, r);
        total++;
        if (r !== 64'd14) begin
            bad++; $display("FAIL divu: got %h want e", r);
        end
    endtask

    task automatic test_bypass();
        int lat, wt;
        logic [63:0] r;
        issue(DIVU, 1'b0, 64'd5, 64'd0, lat, wt, r);
        total++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 1 || wt !== 1) begin
            bad++; $display("FAIL divu_zero: got %h lat=%0d wait=%0d want all-ones/1/1", r, lat, wt);
        end
        issue(REMU, 1'b0, 64'd5, 64'd0, lat, wt, r);
        total++;
        if (r !== 64'd5) begin
            bad++; $display("FAIL remu_zero: got %h want 5", r);
        end
        issue(DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, wt, r);
        total++;
        if (r !== 64'h8000_0000_0000_0000 || lat !== 1) begin
            bad++; $display("FAIL div_ovf: got %h lat=%0d want 8000000000000000/1", r, lat);
        end
        issue(REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, wt, r);
        total++;
        if (r !== 64'h0) begin
            bad++; $display("FAIL rem_ovf: got %h want 0", r);
        end
        issue(DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, wt, r);
        total++;
        if (r !== 64'hFFFF_FFFF_8000_0000 || lat !== 1) begin
            bad++; $display("FAIL divw_ovf: got %h lat=%0d want ffffffff80000000/1", r, lat);
        end
    endtask

    task automatic test_word();
        int lat, wt;
        logic [63:0] r;
        issue(MUL, 1'b1, 64'h1_0000, 64'h1_0000, lat, wt, r);
        total++;
        if (r !== 64'h0 || lat !== 33 || wt !== 33) begin
            bad++; $display("FAIL mulw_wrap: got %h lat=%0d wait=%0d want 0/33/33", r, lat, wt);
        end
        issue(MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, lat, wt, r);
        total++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            bad++; $display("FAIL mulw_sext: got %h want fffffffffffffffe", r);
        end
        issue(DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, lat, wt, r);
        total++;
        if (r !== 64'h0FFF_FFFF || lat !== 33) begin
            bad++; $display("FAIL divuw: got %h lat=%0d want 0fffffff/33", r, lat);
        end
        issue(REM, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, lat, wt, r);
        total++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL remw_neg: got %h want ffffffffffffffff", r);
        end
    endtask

    task automatic test_flush();
        int seen;
        int lat, wt;
        logic [63:0] r;
        @(posedge clk); #1;
        valid = 1'b1; op = MUL; is_word = 1'b0; srca = 64'd123; srcb = 64'd456;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            valid = 1'b0;
        end
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        total++;
        if (exe_is_waiting !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL flush_cycle: wait=%b done=%b want 0/0", exe_is_waiting, done);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        total++;
        if (exe_is_waiting !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL flush_idle: wait=%b done=%b want 0/0", exe_is_waiting, done);
        end
        seen = 0;
        repeat (70) begin
            @(posedge clk); #2;
            seen += int'(done);
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL flush_no_done: done seen %0d times want 0", seen);
        end
        issue(MUL, 1'b0, 64'd3, 64'd4, lat, wt, r);
        total++;
        if (r !== 64'd12 || lat !== 65) begin
            bad++; $display("FAIL after_flush: got %h lat=%0d want c/65", r, lat);
        end
    endtask

    task automatic test_flush_start();
        int seen;
        @(posedge clk); #1;
        valid = 1'b1; flush = 1'b1; op = MUL; is_word = 1'b0; srca = 64'd9; srcb = 64'd9;
        #1;
        total++;
        if (exe_is_waiting !== 1'b0) begin
            bad++; $display("FAIL flush_start_wait: got %b want 0", exe_is_waiting);
        end
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        seen = 0;
        repeat (70) begin
            @(posedge clk); #2;
            seen += int'(done) + int'(exe_is_waiting);
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL flush_start_idle: activity %0d want 0", seen);
        end
    endtask

    task automatic test_stall();
        int dh;
        @(posedge clk); #1;
        valid = 1'b1; op = DIVU; is_word = 1'b0; srca = 64'd5; srcb = 64'd0;
        @(posedge clk); #1;
        stall_out = 1'b1; op = MUL; srca = 64'd3; srcb = 64'd4;
        dh = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            dh += int'(done);
            total++;
            if (result !== 64'hFFFF_FFFF_FFFF_FFFF || exe_is_waiting !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d: result=%h wait=%b want all-ones/0", k, result, exe_is_waiting);
            end
            @(posedge clk); #1;
        end
        stall_out = 1'b0;
        #1;
        dh += int'(done);
        total++;
        if (dh !== 4 || result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL stall_done_len: done cycles=%0d result=%h want 4/all-ones", dh, result);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b0 || exe_is_waiting !== 1'b0) begin
            bad++; $display("FAIL stall_release: done=%b wait=%b want 0/0", done, exe_is_waiting);
        end
    endtask

    task automatic test_back_to_back();
        int lat, wt;
        logic [63:0] r;
        issue(REMU, 1'b0, 64'd100, 64'd7, lat, wt, r);
        issue(DIV, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, lat, wt, r);
        total++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFF2 || lat !== 65 || wt !== 65) begin
            bad++; $display("FAIL b2b: got %h lat=%0d wait=%0d want fffffffffffffff2/65/65", r, lat, wt);
        end
    endtask

    task automatic test_async_reset();
        int lat, wt;
        logic [63:0] r;
        @(posedge clk); #1;
        valid = 1'b1; op = MUL; is_word = 1'b0; srca = 64'd11; srcb = 64'd13;
        repeat (20) begin
            @(posedge clk); #1;
            valid = 1'b0;
        end
        #1;
        total++;
        if (exe_is_waiting !== 1'b1) begin
            bad++; $display("FAIL busy_wait: got %b want 1", exe_is_waiting);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (exe_is_waiting !== 1'b0 || done !== 1'b0 || result !== 64'h0) begin
            bad++; $display("FAIL async_reset_busy: wait=%b done=%b result=%h want 0/0/0", exe_is_waiting, done, result);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        valid = 1'b1; op = DIVU; srca = 64'd5; srcb = 64'd0;
        @(posedge clk); #1;
        valid = 1'b0; stall_out = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (done !== 1'b0 || result !== 64'h0) begin
            bad++; $display("FAIL async_reset_done: done=%b result=%h want 0/0", done, result);
        end
        @(posedge clk); #1;
        reset = 1'b0; stall_out = 1'b0;
        issue(MUL, 1'b0, 64'd3, 64'd4, lat, wt, r);
        total++;
        if (r !== 64'd12 || lat !== 65) begin
            bad++; $display("FAIL after_reset: got %h lat=%0d want c/65", r, lat);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        valid = 1'b0;
        op = 3'b000;
        is_word = 1'b0;
        srca = '0;
        srcb = '0;
        flush = 1'b0;
        stall_out = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_bypass();
        test_word();
        test_flush();
        test_flush_start();
        test_stall();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Iterative 64-bit multiply/divide unit in the EX stage of the five-stage RV64 pipeline, fed by the ID/EX pipeline register. It is the producer of `exe_is_waiting`, the stall signal that makes the ID/EX register re-load its held instruction while a multi-cycle operation is in flight. It returns one 64-bit result per accepted instruction and supports abort on pipeline flush.

## Interface

- `XLEN`, 64: datapath width. Fixed; only 64 is supported.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `valid` in 1: EX holds a non-bubble mul/div instruction this cycle.
- `op` in 3: 000 MUL (low XLEN bits), 001 DIV, 010 DIVU, 011 REM, 100 REMU. Other codes behave as MUL.
- `is_word` in 1: RV64 *W variant; operates on bits [31:0].
- `srca` in 64: multiplicand / dividend.
- `srcb` in 64: multiplier / divisor.
- `flush` in 1: EX instruction is squashed this cycle.
- `stall_out` in 1: downstream stall (memory wait); the pipeline does not advance.
- `exe_is_waiting` out 1: operation in progress; ID/EX must hold.
- `result` out 64: final result, valid only while `done`=1.
- `done` out 1: result valid this cycle.

## Operation

- States: IDLE, BUSY, DONE. Reset state is IDLE. Reset values: `result`=0, `done`=0, iteration counter=0, all internal operand/accumulator registers=0.
- `exe_is_waiting` = (IDLE & `valid` & !`flush`) | (BUSY & !`flush`). It is combinational, so the start cycle already holds ID/EX.
- IDLE -> BUSY: when `valid` & !`flush`. Latch the operands and the op.
  - Word ops: extend operands from bit 31. Sign-extend for MUL/DIV/REM; zero-extend for DIVU/REMU.
  - Signed division: latch magnitudes plus the quotient-negate and remainder-negate flags.
- IDLE -> DONE (bypass), when `valid` & !`flush` and one of these holds:
  - Divisor zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (most-negative / -1, at word or full width): DIV = dividend; REM = 0.
- BUSY: one iteration per cycle.
  - MUL is radix-2 shift-add on the unsigned bit patterns; the low bits are sign-independent.
  - DIV uses restoring shift-subtract.
  - Iteration count is 64, or 32 when `is_word`=1.
  - After the last iteration, go to DONE. Apply sign fixes: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
- DONE: `done`=1. `result` = final value; for word ops it is the low 32 bits sign-extended to 64.
  - Stay in DONE while `stall_out`=1. `result` is held stable, and no new start is taken.
  - Go to IDLE when `stall_out`=0.
- `flush` in any state: go to IDLE next cycle. Drop the partial state and set `done`=0. No result is produced.
- Arithmetic: the accumulator is 2×XLEN wide internally; only the low XLEN bits are the MUL result.

## Timing

- S = first cycle `valid` is seen in IDLE.
- Full width: `exe_is_waiting` is high from S to S+64; DONE at S+65.
- Word ops: `exe_is_waiting` is high from S to S+32; DONE at S+33.
- Bypass cases: `exe_is_waiting` is high at S only; DONE at S+1.
- `done` lasts 1 cycle when `stall_out`=0, otherwise until `stall_out` falls.
- A new operation can start at the earliest in the cycle after DONE is left. Back-to-back ops have no extra gap.
- `flush` asserted together with `valid` in IDLE: no start, and `exe_is_waiting`=0.
- `reset` during BUSY: asynchronously returns to IDLE and clears all outputs.

## Test plan

- MUL with `srca`=7, `srcb`=0xFFFF_FFFF_FFFF_FFFD -> `result`=0xFFFF_FFFF_FFFF_FFEB, `done` at S+65, `exe_is_waiting` high S..S+64.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF. REMU 100/7 -> 2.
- DIVU 5/0 -> all ones at S+1. DIV with 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same operands -> 0.
- DIVW with 0x0000_0000_8000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_8000_0000 at S+1. MULW 0x10000×0x10000 -> 0, `done` at S+33.
- `flush` at S+10 -> `exe_is_waiting` low that cycle, IDLE at S+11, no `done`. A following MUL 3×4 -> 12.
- `stall_out` high for 3 cycles in DONE -> `done` and `result` stable for 3+1 cycles, no restart. Async `reset` mid-BUSY -> all outputs 0 immediately.
